// File: rtl/mdio_controller_if.sv
// MDIO controller signal bundle: CPU request/response plus PHY-side serial lines.
// The slave modport is the controller; the master modport is the CPU/PHY side.
interface mdio_controller_if;
  logic        MDIO_START;
  logic [31:0] T_DATA;
  logic        MDIO_IN;
  logic        MDC;
  logic        MDIO_OUT;
  logic        MDIO_OE;
  logic [15:0] RD_DATA;
  logic        DATA_RDY;
  logic        BUSY;

  modport slave (
    input  MDIO_START, T_DATA, MDIO_IN,
    output MDC, MDIO_OUT, MDIO_OE, RD_DATA, DATA_RDY, BUSY
  );

  modport master (
    output MDIO_START, T_DATA, MDIO_IN,
    input  MDC, MDIO_OUT, MDIO_OE, RD_DATA, DATA_RDY, BUSY
  );
endinterface

// File: rtl/mdio_controller.sv
// Clause 22 MDIO host transaction generator.
// MDC is a free-running divide of clk; frame bits launch at MDC falls, read data
// is sampled at MDC rises. Define MDIO_PREAMBLE_EN to prepend 32 preamble ones;
// without it the frame starts directly with ST (preamble suppression).
module mdio_controller #(
  parameter int unsigned CLK_DIV = 2
) (
  input logic              clk,
  input logic              reset,
  mdio_controller_if.slave bus
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  // StStart holds BUSY while waiting for the first MDC fall of the frame.
  typedef enum logic [2:0] {
    StIdle, StStart, StPreamble, StWrFrame, StRdHdr, StRdTa, StRdData, StDone
  } state_e;

  state_e          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [5:0]      last_bit;
  logic [DivW-1:0] div_q;
  logic            mdc_q;
  logic [31:0]     tdata_q;
  logic [15:0]     shift_q, rd_data_q;
  logic            out_q, out_d, oe_q, oe_d;
  logic            busy_q, busy_d, data_rdy_q, data_rdy_d;
  logic            tick, mdc_rise, mdc_fall, op_legal, accept, is_read;

  assign tick     = (div_q == DivLast);
  assign mdc_rise = tick & ~mdc_q;
  assign mdc_fall = tick & mdc_q;
  assign op_legal = (bus.T_DATA[29:28] == 2'b01) | (bus.T_DATA[29:28] == 2'b10);
  assign accept   = (state_q == StIdle) & bus.MDIO_START & op_legal;
  assign is_read  = (tdata_q[29:28] == 2'b10);

  // Free-running MDC divider, independent of frame activity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      mdc_q <= 1'b0;
    end else if (tick) begin
      div_q <= '0;
      mdc_q <= ~mdc_q;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Index of the final MDC period of the current phase.
  always_comb begin
    case (state_q)
      StPreamble, StWrFrame: last_bit = 6'd31;
      StRdHdr:               last_bit = 6'd13;
      StRdTa:                last_bit = 6'd1;
      StRdData:              last_bit = 6'd15;
      default:               last_bit = 6'd0;
    endcase
  end

  // State and bit-counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: phases advance on MDC falls; cnt_q is the bit index on the wire.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (mdc_fall) begin
`ifdef MDIO_PREAMBLE_EN
          state_d = StPreamble;
`else
          state_d = is_read ? StRdHdr : StWrFrame;
`endif
          cnt_d   = '0;
        end
      end
      StDone: state_d = StIdle;
      default: begin
        if (mdc_fall) begin
          if (cnt_q == last_bit) begin
            cnt_d = '0;
            case (state_q)
              StPreamble: state_d = is_read ? StRdHdr : StWrFrame;
              StRdHdr:    state_d = StRdTa;
              StRdTa:     state_d = StRdData;
              default:    state_d = StDone;
            endcase
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
    endcase
  end

  // Outputs: serial line launched at MDC fall from the phase being entered/continued.
  always_comb begin
    out_d = out_q;
    oe_d  = oe_q;
    if (mdc_fall) begin
      case (state_d)
        StPreamble: begin
          oe_d  = 1'b1;
          out_d = 1'b1;
        end
        StWrFrame, StRdHdr: begin
          oe_d  = 1'b1;
          out_d = tdata_q[~cnt_d[4:0]];
        end
        default: begin
          oe_d  = 1'b0;
          out_d = 1'b0;
        end
      endcase
    end
    busy_d     = (state_d != StIdle);
    data_rdy_d = (state_d == StDone) & is_read;
  end

  // Output, request latch and read-data registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q      <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      data_rdy_q <= 1'b0;
      tdata_q    <= '0;
      shift_q    <= '0;
      rd_data_q  <= '0;
    end else begin
      out_q      <= out_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      data_rdy_q <= data_rdy_d;
      if (accept) tdata_q <= bus.T_DATA;
      if (mdc_rise && state_q == StRdData) shift_q <= {shift_q[14:0], bus.MDIO_IN};
      if (data_rdy_d) rd_data_q <= shift_q;
    end
  end

  assign bus.MDC      = mdc_q;
  assign bus.MDIO_OUT = out_q;
  assign bus.MDIO_OE  = oe_q;
  assign bus.BUSY     = busy_q;
  assign bus.DATA_RDY = data_rdy_q;
  assign bus.RD_DATA  = rd_data_q;

endmodule
